fifo_requester: RTL and testbench

Bus-side master for the 8-deep FIFO. It takes a single burst command (write N words or read N words) and drives the FIFO's `wr_en`/`rd_en`/`din`. It then consumes the FIFO's handshake outputs (`wr_ack`, `wr_err`, `rd_ack`, `rd_err`, `full`, `empty`) to confirm every word, retry on error, and report a completion status. It sits between the test/host logic and the FIFO top.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_requester_if.sv | 30 +++
 rtl/fifo_resp_dec.sv | 31 +++
 rtl/fifo_requester.sv | 161 ++++++++++++++++
 tb/tb_fifo_requester.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO bus requester.
// FIFO_REQ_RETRY_EN compiles in the RETRY state and retry counter.
package fifo_pkg;

  localparam int FIFO_DEPTH = 8;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
`ifdef FIFO_REQ_RETRY_EN
    ST_RETRY = 3'd3,
`endif
    ST_DONE  = 3'd4
  } req_state_t;

  typedef enum logic [1:0] {
    RESP_OK    = 2'd0,
    RESP_ERR   = 2'd1,
    RESP_FAULT = 2'd2
  } resp_t;

endpackage

// File: rtl/fifo_requester_if.sv
// FIFO request/handshake bundle between the requester and the FIFO.
// The master side drives requests, the slave side answers them.
interface fifo_requester_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  modport master (
    output wr_en, rd_en, din,
    input  dout, full, empty,
    input  wr_ack, wr_err, rd_ack, rd_err
  );

  modport slave (
    input  wr_en, rd_en, din,
    output dout, full, empty,
    output wr_ack, wr_err, rd_ack, rd_err
  );

endinterface

// File: rtl/fifo_resp_dec.sv
// Classifies the FIFO handshake for the current direction.
// Wrong-direction or missing/contradictory responses are faults.
module fifo_resp_dec
  import fifo_pkg::*;
(
  input  logic  op,
  input  logic  wr_ack,
  input  logic  wr_err,
  input  logic  rd_ack,
  input  logic  rd_err,
  output resp_t resp
);

  logic own_ack;
  logic own_err;
  logic other;

  always_comb begin
    own_ack = (op == OP_WRITE) ? wr_ack : rd_ack;
    own_err = (op == OP_WRITE) ? wr_err : rd_err;
    other   = (op == OP_WRITE) ? (rd_ack | rd_err)
                               : (wr_ack | wr_err);
    resp = RESP_FAULT;
    unique case (1'b1)
      (!other &&  own_ack && !own_err): resp = RESP_OK;
      (!other && !own_ack &&  own_err): resp = RESP_ERR;
      default:                          resp = RESP_FAULT;
    endcase
  end

endmodule

// File: rtl/fifo_requester.sv
// Burst master for the 8-deep FIFO: issues, confirms and reports words.
// FIFO_REQ_RETRY_EN enables per-word retry up to MAX_RETRY.
module fifo_requester
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
`ifdef FIFO_REQ_RETRY_EN
  ,
  parameter int MAX_RETRY  = 3
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [3:0]            len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            xfer_cnt,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_data_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  fifo_requester_if.master      fifo
);

  req_state_t            state_q, state_d;
  logic                  op_q, op_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            xfer_d;
  logic [3:0]            xfer_inc;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] rdat_d;
  logic                  rvld_d;
  resp_t                 resp;

`ifdef FIFO_REQ_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_q, retry_d;
  logic          fifo_ready;
  assign fifo_ready = (op_q == OP_WRITE) ? !fifo.full : !fifo.empty;
`endif

  fifo_resp_dec u_dec (
    .op     (op_q),
    .wr_ack (fifo.wr_ack),
    .wr_err (fifo.wr_err),
    .rd_ack (fifo.rd_ack),
    .rd_err (fifo.rd_err),
    .resp   (resp)
  );

  assign xfer_inc = xfer_cnt + 4'd1;

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fifo.wr_en = (state_q == ST_ISSUE) && (op_q == OP_WRITE);
  assign fifo.rd_en = (state_q == ST_ISSUE) && (op_q == OP_READ);
  assign fifo.din   = fifo.wr_en ? wr_data : '0;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    len_d       = len_q;
    xfer_d      = xfer_cnt;
    err_d       = err;
    rdat_d      = rd_data;
    rvld_d      = 1'b0;
    wr_data_req = 1'b0;
`ifdef FIFO_REQ_RETRY_EN
    retry_d     = retry_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          len_d   = len;
          xfer_d  = '0;
          err_d   = 1'b0;
`ifdef FIFO_REQ_RETRY_EN
          retry_d = '0;
`endif
          state_d = (len == 4'd0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        unique case (resp)
          RESP_OK: begin
            xfer_d = xfer_inc;
`ifdef FIFO_REQ_RETRY_EN
            retry_d = '0;
`endif
            if (op_q == OP_WRITE) begin
              wr_data_req = 1'b1;
            end else begin
              rdat_d = fifo.dout;
              rvld_d = 1'b1;
            end
            state_d = (xfer_inc == len_q) ? ST_DONE : ST_ISSUE;
          end
          RESP_ERR: begin
`ifdef FIFO_REQ_RETRY_EN
            state_d = ST_RETRY;
`else
            err_d   = 1'b1;
            state_d = ST_DONE;
`endif
          end
          default: begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        endcase
      end
`ifdef FIFO_REQ_RETRY_EN
      ST_RETRY: begin
        // Budget check comes first so an exhausted word never waits.
        if (retry_q == RW'(MAX_RETRY)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (fifo_ready) begin
          retry_d = retry_q + 1'b1;
          state_d = ST_ISSUE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_WRITE;
      len_q         <= '0;
      xfer_cnt      <= '0;
      err           <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      len_q         <= len_d;
      xfer_cnt      <= xfer_d;
      err           <= err_d;
      rd_data       <= rdat_d;
      rd_data_valid <= rvld_d;
    end
  end

`ifdef FIFO_REQ_RETRY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retry_q <= '0;
    else          retry_q <= retry_d;
  end
`endif

endmodule

// File: tb/tb_fifo_requester.sv
// Directed bench for fifo_requester against a small 8-deep FIFO model.
// Retry scenarios run only when FIFO_REQ_RETRY_EN is defined.
module tb_fifo_requester;
  import fifo_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          op;
  logic [3:0]    len;
  logic          busy;
  logic          done;
  logic          err;
  logic [3:0]    xfer_cnt;
  logic [DW-1:0] wr_data;
  logic          wr_data_req;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;

  fifo_requester_if #(.DATA_WIDTH(DW)) bus ();

  fifo_requester #(.DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .op            (op),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .xfer_cnt      (xfer_cnt),
    .wr_data       (wr_data),
    .wr_data_req   (wr_data_req),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .fifo          (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // FIFO model: responses registered, valid the cycle after a request
  logic          mute;
  logic          force_err;
  logic          ext_wr;
  logic [DW-1:0] ext_din;
  logic [DW-1:0] mem [FIFO_DEPTH];
  int            cnt, wp, rp;

  assign bus.full  = (cnt == FIFO_DEPTH);
  assign bus.empty = (cnt == 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 0; wp <= 0; rp <= 0;
      bus.wr_ack <= 1'b0; bus.wr_err <= 1'b0;
      bus.rd_ack <= 1'b0; bus.rd_err <= 1'b0;
      bus.dout <= '0;
    end else begin
      bus.wr_ack <= 1'b0; bus.wr_err <= 1'b0;
      bus.rd_ack <= 1'b0; bus.rd_err <= 1'b0;
      if (!mute) begin
        if (bus.wr_en || ext_wr) begin
          if (cnt < FIFO_DEPTH && !force_err) begin
            mem[wp] <= bus.wr_en ? bus.din : ext_din;
            wp <= (wp + 1) % FIFO_DEPTH;
            cnt <= cnt + 1;
            bus.wr_ack <= bus.wr_en;
          end else begin
            bus.wr_err <= 1'b1;
          end
        end else if (bus.rd_en) begin
          if (cnt != 0 && !force_err) begin
            bus.dout <= mem[rp];
            rp <= (rp + 1) % FIFO_DEPTH;
            cnt <= cnt - 1;
            bus.rd_ack <= 1'b1;
          end else begin
            bus.rd_err <= 1'b1;
          end
        end
      end
    end
  end

  // Upstream write source and output monitors
  logic [DW-1:0] wq [16];
  int            n_req = 0;
  int            req_base = 0;
  int            n_rv = 0;
  int            n_en = 0;
  int            n_done = 0;
  logic [DW-1:0] rd_log [32];

  always_comb wr_data = wq[(n_req - req_base) % 16];

  always @(posedge clk) if (wr_data_req) n_req <= n_req + 1;

  always @(negedge clk) begin
    if (rd_data_valid) begin
      if (n_rv < 32) rd_log[n_rv] = rd_data;
      n_rv++;
    end
    if (bus.wr_en || bus.rd_en) n_en++;
    if (done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic o, input logic [3:0] n, output int cyc);
    start = 1'b1; op = o; len = n;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, b, rv0, en0, nd0;
    reset_n = 1'b0; start = 1'b0; op = 1'b0; len = '0;
    mute = 1'b0; force_err = 1'b0; ext_wr = 1'b0; ext_din = '0;
    for (int i = 0; i < 16; i++) wq[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_err",   err, 0);
    chk("rst_xfer",  xfer_cnt, 0);
    chk("rst_rdata", rd_data, 0);
    chk("rst_en",    {bus.wr_en, bus.rd_en, wr_data_req, rd_data_valid}, 0);
    reset_n = 1'b1;
    tick();

    // write 3 words
    req_base = n_req;
    wq[0] = 32'hA0; wq[1] = 32'hA1; wq[2] = 32'hA2;
    b = n_req;
    run(OP_WRITE, 4'd3, cyc);
    chk("w3_cyc",  cyc, 7);
    chk("w3_xfer", xfer_cnt, 3);
    chk("w3_err",  err, 0);
    tick();
    chk("w3_req",  n_req - b, 3);
    chk("w3_idle", busy, 0);

    // read them back
    rv0 = n_rv;
    run(OP_READ, 4'd3, cyc);
    chk("r3_cyc",  cyc, 7);
    chk("r3_xfer", xfer_cnt, 3);
    chk("r3_err",  err, 0);
    tick();
    chk("r3_nrv", n_rv - rv0, 3);
    chk("r3_d0",  rd_log[rv0],     32'hA0);
    chk("r3_d1",  rd_log[rv0 + 1], 32'hA1);
    chk("r3_d2",  rd_log[rv0 + 2], 32'hA2);

`ifndef FIFO_REQ_RETRY_EN
    // overflow: 8 acks then wr_err aborts
    req_base = n_req;
    for (int i = 0; i < 10; i++) wq[i] = 32'hB0 + i;
    b = n_req;
    run(OP_WRITE, 4'd10, cyc);
    chk("ovf_cyc",  cyc, 19);
    chk("ovf_xfer", xfer_cnt, 8);
    chk("ovf_err",  err, 1);
    tick();
    chk("ovf_req",  n_req - b, 8);
    rv0 = n_rv;
    run(OP_READ, 4'd8, cyc);
    chk("drn_cyc", cyc, 17);
    chk("drn_err", err, 0);
    tick();
    chk("drn_d0", rd_log[rv0],     32'hB0);
    chk("drn_d7", rd_log[rv0 + 7], 32'hB7);
`endif

    // no response at all is a fault
    mute = 1'b1;
    req_base = n_req;
    b = n_req;
    run(OP_WRITE, 4'd2, cyc);
    chk("flt_cyc",  cyc, 3);
    chk("flt_err",  err, 1);
    chk("flt_xfer", xfer_cnt, 0);
    tick();
    chk("flt_req",  n_req - b, 0);
    mute = 1'b0;

    // zero-length burst
    en0 = n_en;
    run(OP_READ, 4'd0, cyc);
    chk("z_cyc", cyc, 1);
    chk("z_err", err, 0);
    tick();
    chk("z_en",  n_en - en0, 0);

    // reset during WAIT of word 2 of 4
    req_base = n_req;
    for (int i = 0; i < 4; i++) wq[i] = 32'hC0 + i;
    start = 1'b1; op = OP_WRITE; len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) tick();
    chk("mr_busy", busy, 1);
    chk("mr_xfer", xfer_cnt, 1);
    nd0 = n_done;
    #2 reset_n = 1'b0;
    #1;
    chk("mr_rbusy",  busy, 0);
    chk("mr_rreq",   {bus.wr_en, bus.rd_en, wr_data_req}, 0);
    chk("mr_rxfer",  xfer_cnt, 0);
    chk("mr_rrdata", rd_data, 0);
    #3 reset_n = 1'b1;
    tick();
    tick();
    chk("mr_nodone", n_done - nd0, 0);
    req_base = n_req;
    wq[0] = 32'hD0; wq[1] = 32'hD1;
    run(OP_WRITE, 4'd2, cyc);
    chk("pr_cyc",  cyc, 5);
    chk("pr_xfer", xfer_cnt, 2);
    chk("pr_err",  err, 0);
    tick();
    rv0 = n_rv;
    run(OP_READ, 4'd2, cyc);
    chk("pr_rcyc", cyc, 5);
    tick();
    chk("pr_d0", rd_log[rv0],     32'hD0);
    chk("pr_d1", rd_log[rv0 + 1], 32'hD1);

`ifdef FIFO_REQ_RETRY_EN
    // read stalls in RETRY until an external write lands
    nd0 = n_done;
    start = 1'b1; op = OP_READ; len = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) tick();
    chk("st_busy", busy, 1);
    chk("st_done", n_done - nd0, 0);
    ext_wr = 1'b1; ext_din = 32'hE5;
    tick();
    ext_wr = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("st_fin",  done, 1);
    chk("st_err",  err, 0);
    chk("st_xfer", xfer_cnt, 1);
    tick();
    chk("st_data", rd_data, 32'hE5);

    // every read errors: 3 retries then abort
    ext_wr = 1'b1; ext_din = 32'hF0;
    tick();
    ext_wr = 1'b0;
    force_err = 1'b1;
    en0 = n_en;
    run(OP_READ, 4'd1, cyc);
    chk("ex_cyc",  cyc, 13);
    chk("ex_err",  err, 1);
    chk("ex_xfer", xfer_cnt, 0);
    tick();
    chk("ex_req",  n_en - en0, 4);
    force_err = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
